// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants and lookahead helpers for the pipelined carry-lookahead adder.
// The lookahead helper works on a 32-bit window so one function serves bits and groups.
package cla_pipe_adder_pkg;

   localparam int CLA_WIDTH  = 16;
   localparam int CLA_GROUP  = 4;
   localparam int CLA_LA_MAX = 32;

   function automatic int cla_ngroup(input int width, input int group);
      if (group > 0) begin
         return width / group;
      end else begin
         return 0;
      end
   endfunction

   function automatic bit cla_width_ok(input int width, input int group);
      return (group >= 1) && (group <= CLA_LA_MAX) && (width >= group) &&
             ((width % group) == 0) && ((width / group) <= CLA_LA_MAX);
   endfunction

   // Flat sum-of-products carry into position 'upto'; positions at or above 'upto' are masked.
   function automatic logic cla_la_carry(input logic [31:0] p, input logic [31:0] g,
                                         input logic cin, input int upto);
      logic acc;
      logic run;
      acc = 1'b0;
      run = 1'b0;
      for (int j = 0; j < CLA_LA_MAX; j++) begin
         run = g[j] & (j < upto);
         for (int k = j + 1; k < CLA_LA_MAX; k++) begin
            run = run & (p[k] | (k >= upto));
         end
         acc = acc | run;
      end
      run = cin;
      for (int k = 0; k < CLA_LA_MAX; k++) begin
         run = run & (p[k] | (k >= upto));
      end
      return acc | run;
   endfunction

endpackage

// File: rtl/cla_pipe_adder_group_pg.sv
// One lookahead group: group propagate/generate and the carry into every bit of the group,
// each carry formed directly from the group carry-in rather than rippled bit to bit.
module cla_pipe_adder_group_pg
   import cla_pipe_adder_pkg::*;
#(
   parameter int GROUP = CLA_GROUP
)
(
   input  logic [GROUP-1:0] i_p,
   input  logic [GROUP-1:0] i_g,
   input  logic             i_cin,
   output logic             o_pstar,
   output logic             o_gstar,
   output logic [GROUP-1:0] o_carry
);

   // Group P*/G* and per-bit lookahead carries
   always_comb begin
      o_pstar = &i_p;
      o_gstar = cla_la_carry(32'(i_p), 32'(i_g), 1'b0, GROUP);
      o_carry = '0;
      for (int i = 0; i < GROUP; i++) begin
         o_carry[i] = cla_la_carry(32'(i_p), 32'(i_g), i_cin, i);
      end
   end

endmodule

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Stage 1 registers bit and group P/G; stage 2 resolves carries and registers the sum.
module cla_pipe_adder
   import cla_pipe_adder_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH,
   parameter int GROUP = CLA_GROUP
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int NGROUP = cla_ngroup(WIDTH, GROUP);

   generate
      if (!cla_width_ok(WIDTH, GROUP)) begin : g_width_err
         $error("cla_pipe_adder: WIDTH must be a non-zero multiple of GROUP");
      end
   endgenerate

   logic              w_s2_take;
   logic              w_in_fire;
   logic [WIDTH-1:0]  w_p;
   logic [WIDTH-1:0]  w_g;
   logic [NGROUP-1:0] w_s1_pstar;
   logic [NGROUP-1:0] w_s1_gstar;

   logic              r_s1_valid;
   logic [WIDTH-1:0]  r_s1_p;
   logic [WIDTH-1:0]  r_s1_g;
   logic [NGROUP-1:0] r_s1_pstar;
   logic [NGROUP-1:0] r_s1_gstar;
   logic              r_s1_cin;

   logic [NGROUP:0]   w_gc;
   wire  [WIDTH-1:0]  w_bc;
   wire  [NGROUP-1:0] w_s2_pstar_unused;
   wire  [NGROUP-1:0] w_s2_gstar_unused;
   logic [WIDTH-1:0]  w_sum;
   logic              w_cout;
   logic              w_ovf;

   logic              r_out_valid;
   logic [WIDTH-1:0]  r_sum;
   logic              r_cout;
   logic              r_ovf;

   // Stage 2 frees up whenever it is empty or its result leaves this cycle.
   assign w_s2_take = ~r_out_valid | out_ready;
   assign in_ready  = ~r_s1_valid | w_s2_take;
   assign w_in_fire = in_valid & in_ready;
   assign w_p       = a ^ b;
   assign w_g       = a & b;

   // Group P*/G* from the incoming operands
   always_comb begin
      w_s1_pstar = '0;
      w_s1_gstar = '0;
      for (int gi = 0; gi < NGROUP; gi++) begin
         w_s1_pstar[gi] = &w_p[gi*GROUP +: GROUP];
         w_s1_gstar[gi] = cla_la_carry(32'(w_p[gi*GROUP +: GROUP]),
                                       32'(w_g[gi*GROUP +: GROUP]), 1'b0, GROUP);
      end
   end

   // Stage 1 register: data loads only on an accepted transfer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_p     <= '0;
         r_s1_g     <= '0;
         r_s1_pstar <= '0;
         r_s1_gstar <= '0;
         r_s1_cin   <= 1'b0;
      end else if (w_in_fire) begin
         r_s1_valid <= 1'b1;
         r_s1_p     <= w_p;
         r_s1_g     <= w_g;
         r_s1_pstar <= w_s1_pstar;
         r_s1_gstar <= w_s1_gstar;
         r_s1_cin   <= c_in;
      end else if (w_s2_take) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Group carries, each a flat lookahead over all lower groups and the carry-in
   always_comb begin
      w_gc    = '0;
      w_gc[0] = r_s1_cin;
      for (int gi = 1; gi <= NGROUP; gi++) begin
         w_gc[gi] = cla_la_carry(32'(r_s1_pstar), 32'(r_s1_gstar), r_s1_cin, gi);
      end
   end

   genvar gv;
   generate
      for (gv = 0; gv < NGROUP; gv++) begin : g_grp
         cla_pipe_adder_group_pg #(
            .GROUP (GROUP)
         ) u_pg (
            .i_p     (r_s1_p[gv*GROUP +: GROUP]),
            .i_g     (r_s1_g[gv*GROUP +: GROUP]),
            .i_cin   (w_gc[gv]),
            .o_pstar (w_s2_pstar_unused[gv]),
            .o_gstar (w_s2_gstar_unused[gv]),
            .o_carry (w_bc[gv*GROUP +: GROUP])
         );
      end
   endgenerate

   assign w_sum  = r_s1_p ^ w_bc;
   assign w_cout = w_gc[NGROUP];
   assign w_ovf  = w_bc[WIDTH-1] ^ w_cout;

   // Stage 2 register: result holds while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
      end else if (w_s2_take) begin
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_sum  <= w_sum;
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
         end
      end
   end

   assign out_valid = r_out_valid;
   assign sum       = r_sum;
   assign c_out     = r_cout;
   assign overflow  = r_ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed self-checking bench for cla_pipe_adder (WIDTH=16, GROUP=4).
module tb_cla_pipe_adder;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        c_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        c_out;
   logic        overflow;

   int n_checks = 0;
   int n_errors = 0;

   cla_pipe_adder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .c_in      (c_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .c_out     (c_out),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One isolated operation with out_ready=1; checks latency and all result fields.
   task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv,
                         input logic tc, input logic [15:0] es, input logic ec, input logic eo);
      int lat;
      @(negedge clk);
      a = ta; b = tbv; c_in = tc; in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({tag, "_rdy"}, 32'(in_ready), 32'h1);
      @(negedge clk);
      in_valid = 1'b0; a = 16'h0000; b = 16'h0000; c_in = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 8) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"},  32'(lat),      32'd2);
      chk({tag, "_sum"},  32'(sum),      32'(es));
      chk({tag, "_cout"}, 32'(c_out),    32'(ec));
      chk({tag, "_ovf"},  32'(overflow), 32'(eo));
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; c_in = 1'b0; out_ready = 1'b0;

      @(negedge clk);
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_sum",   32'(sum),       32'h0);
      chk("rst_cout",  32'(c_out),     32'h0);
      chk("rst_ovf",   32'(overflow),  32'h0);
      chk("rst_rdy",   32'(in_ready),  32'h1);
      rst = 1'b0;

      run_op("basic",  16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
      run_op("chain1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("chain2", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_op("ovf1",   16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
      run_op("ovf2",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
      run_op("grpc",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
      run_op("prop",   16'hA5A5, 16'h5A5A, 1'b1, 16'h0000, 1'b1, 1'b0);

      // Backpressure: consumer stalled from the first issue
      @(negedge clk);
      out_ready = 1'b0; a = 16'h0001; b = 16'h0001; c_in = 1'b0; in_valid = 1'b1;
      #1 chk("bp_rdy0", 32'(in_ready), 32'h1);
      @(negedge clk);
      a = 16'h0002; b = 16'h0002;
      #1 chk("bp_rdy1", 32'(in_ready), 32'h1);
      chk("bp_v1", 32'(out_valid), 32'h0);
      @(negedge clk);
      a = 16'h0003; b = 16'h0003;
      #1 chk("bp_rdy2", 32'(in_ready), 32'h0);
      chk("bp_v2",   32'(out_valid), 32'h1);
      chk("bp_sum2", 32'(sum),       32'h2);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("bp_hold_sum", 32'(sum),       32'h2);
         chk("bp_hold_v",   32'(out_valid), 32'h1);
         chk("bp_hold_rdy", 32'(in_ready),  32'h0);
      end
      out_ready = 1'b1;
      #1 chk("bp_rdy3", 32'(in_ready), 32'h1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("bp_v4",   32'(out_valid), 32'h1);
      chk("bp_sum4", 32'(sum),       32'h4);
      @(negedge clk);
      chk("bp_v6",   32'(out_valid), 32'h1);
      chk("bp_sum6", 32'(sum),       32'h6);
      @(negedge clk);
      chk("bp_drain", 32'(out_valid), 32'h0);

      // Throughput: eight back-to-back operations
      out_ready = 1'b1;
      for (int t = 0; t < 12; t++) begin
         @(negedge clk);
         chk("tp_valid", 32'(out_valid), (t >= 2 && t < 10) ? 32'h1 : 32'h0);
         if (t >= 2 && t < 10) begin
            chk("tp_sum", 32'(sum), 32'h100 + 32'(t - 2));
         end
         if (t < 8) begin
            a = 16'(t); b = 16'h0100; c_in = 1'b0; in_valid = 1'b1;
            #1 chk("tp_rdy", 32'(in_ready), 32'h1);
         end else begin
            in_valid = 1'b0;
         end
      end

      // Asynchronous reset with two operations in flight
      @(negedge clk);
      out_ready = 1'b0; a = 16'hC000; b = 16'h8001; c_in = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      a = 16'h0005; b = 16'h0005;
      @(negedge clk);
      in_valid = 1'b0;
      #1 chk("rm_pre_v", 32'(out_valid), 32'h1);
      chk("rm_pre_sum",  32'(sum),      32'h4001);
      chk("rm_pre_cout", 32'(c_out),    32'h1);
      chk("rm_pre_ovf",  32'(overflow), 32'h1);
      chk("rm_pre_rdy",  32'(in_ready), 32'h0);
      #2 rst = 1'b1;
      #1 chk("rm_v", 32'(out_valid), 32'h0);
      chk("rm_sum",  32'(sum),      32'h0);
      chk("rm_cout", 32'(c_out),    32'h0);
      chk("rm_ovf",  32'(overflow), 32'h0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rm_stale", 32'(out_valid), 32'h0);
      end
      run_op("rm_new", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
